tcdm_rr_arbiter: RTL and testbench

- Shares one TCDM memory port between N_PORTS requesters, for example the RedMulE streamer load/store channels plus a debug or DMA port, in front of the testbench or real TCDM memory model.
- Arbitration is round-robin and work-conserving. The memory port grants in the same cycle as the request and returns r_valid/r_data in order.
- Tracks the requester of each outstanding transaction in an ID FIFO, so every response is routed back to its originator.

---
 rtl/tcdm_arb_pkg.sv | 25 ++
 rtl/tcdm_rr_arbiter_if.sv | 44 ++++
 rtl/tcdm_arb_id_fifo.sv | 64 ++++++
 rtl/tcdm_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_tcdm_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_arb_pkg.sv
// Shared constants, types and helpers for the TCDM round-robin arbiter.
//   id_width()  : bits needed to name one requester port (never less than 1)
//   tcdm_req_t  : one TCDM request (address, read/write, byte enables, write data)
//                 at the default widths
package tcdm_arb_pkg;

    localparam int unsigned DefNPorts         = 4;
    localparam int unsigned DefAddrW          = 32;
    localparam int unsigned DefDataW          = 32;
    localparam int unsigned DefMaxOutstanding = 2;

    function automatic int unsigned id_width(input int unsigned n_ports);
        int unsigned w;
        w = $clog2(n_ports);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic [DefAddrW-1:0]   add;
        logic                  wen;   // 1 = read, 0 = write
        logic [DefDataW/8-1:0] be;
        logic [DefDataW-1:0]   data;
    } tcdm_req_t;

endpackage

// File: rtl/tcdm_rr_arbiter_if.sv
// Bus bundle between N_PORTS TCDM requesters, the arbiter and one TCDM memory port.
//   in_*  : requester side (request, grant, fields, routed response)
//   out_* : memory side (request, grant, fields, response)
// Modports: slave = the arbiter, master = whatever drives the requesters and the memory.
interface tcdm_rr_arbiter_if #(
    parameter int unsigned N_PORTS = tcdm_arb_pkg::DefNPorts,
    parameter int unsigned ADDR_W  = tcdm_arb_pkg::DefAddrW,
    parameter int unsigned DATA_W  = tcdm_arb_pkg::DefDataW
);
    localparam int unsigned BeW = DATA_W / 8;

    logic [N_PORTS-1:0]             in_req_i;
    logic [N_PORTS-1:0]             in_gnt_o;
    logic [N_PORTS-1:0][ADDR_W-1:0] in_add_i;
    logic [N_PORTS-1:0]             in_wen_i;
    logic [N_PORTS-1:0][BeW-1:0]    in_be_i;
    logic [N_PORTS-1:0][DATA_W-1:0] in_data_i;
    logic [N_PORTS-1:0]             in_r_valid_o;
    logic [DATA_W-1:0]              in_r_data_o;

    logic                           out_req_o;
    logic                           out_gnt_i;
    logic [ADDR_W-1:0]              out_add_o;
    logic                           out_wen_o;
    logic [BeW-1:0]                 out_be_o;
    logic [DATA_W-1:0]              out_data_o;
    logic                           out_r_valid_i;
    logic [DATA_W-1:0]              out_r_data_i;

    modport slave (
        input  in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
        output in_gnt_o, in_r_valid_o, in_r_data_o,
        output out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o,
        input  out_gnt_i, out_r_valid_i, out_r_data_i
    );

    modport master (
        output in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
        input  in_gnt_o, in_r_valid_o, in_r_data_o,
        input  out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o,
        output out_gnt_i, out_r_valid_i, out_r_data_i
    );

endinterface

// File: rtl/tcdm_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push_i       : write push_id_i (ignored when full)
//   pop_i        : drop head_o (ignored when empty)
//   head_o       : oldest ID; only meaningful while not empty
//   full_o, empty_o, count_o : registered occupancy
module tcdm_arb_id_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_id_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_en, pop_en;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) wr_ptr_q <= ptr_incr(wr_ptr_q);
            if (pop_en)  rd_ptr_q <= ptr_incr(rd_ptr_q);
            if (push_en && !pop_en) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop_en && !push_en) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin, work-conserving arbiter sharing one TCDM memory port among N_PORTS
// requesters. Grants in the request cycle; responses come back in order and are
// routed to their originator through an ID FIFO.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   bus_io        : requester side and memory side of the TCDM bus
//   outstanding_o : registered count of granted-but-unanswered transactions
//   err_o         : sticky; a response arrived with nothing outstanding
module tcdm_rr_arbiter import tcdm_arb_pkg::*; #(
    parameter int unsigned N_PORTS         = DefNPorts,
    parameter int unsigned ADDR_W          = DefAddrW,
    parameter int unsigned DATA_W          = DefDataW,
    parameter int unsigned MAX_OUTSTANDING = DefMaxOutstanding,
    localparam int unsigned CntW           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    tcdm_rr_arbiter_if.slave   bus_io,
    output logic [CntW-1:0]    outstanding_o,
    output logic               err_o
);

    localparam int unsigned IdW = id_width(N_PORTS);
    localparam int unsigned BeW = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] add;
        logic              wen;
        logic [BeW-1:0]    be;
        logic [DATA_W-1:0] data;
    } req_t;

    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] winner;
    logic [IdW-1:0] head;
    logic           fifo_full, fifo_empty;
    logic           out_req, handshake, pop;
    logic           err_q;
    req_t           win_req;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx    = 0;
        found  = 1'b0;
        winner = ptr_q;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            idx = (32'(ptr_q) + i) % N_PORTS;
            if (!found && bus_io.in_req_i[idx]) begin
                found  = 1'b1;
                winner = IdW'(idx);
            end
        end
    end

    // Full is judged on registered occupancy, so a same-cycle response never
    // opens a path from out_r_valid_i to out_req_o.
    assign out_req   = (|bus_io.in_req_i) & ~fifo_full & ~rst_i;
    assign handshake = out_req & bus_io.out_gnt_i;
    assign pop       = bus_io.out_r_valid_i & ~fifo_empty & ~rst_i;

    always_comb begin
        win_req = '0;
        if (out_req) begin
            win_req.add  = bus_io.in_add_i[winner];
            win_req.wen  = bus_io.in_wen_i[winner];
            win_req.be   = bus_io.in_be_i[winner];
            win_req.data = bus_io.in_data_i[winner];
        end
    end

    assign bus_io.out_req_o  = out_req;
    assign bus_io.out_add_o  = win_req.add;
    assign bus_io.out_wen_o  = win_req.wen;
    assign bus_io.out_be_o   = win_req.be;
    assign bus_io.out_data_o = win_req.data;

    always_comb begin
        bus_io.in_gnt_o = '0;
        if (handshake) bus_io.in_gnt_o[winner] = 1'b1;
    end

    always_comb begin
        bus_io.in_r_valid_o = '0;
        if (pop) bus_io.in_r_valid_o[head] = 1'b1;
    end

    assign bus_io.in_r_data_o = bus_io.out_r_data_i;

    always_comb begin
        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (winner == IdW'(N_PORTS - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            if (bus_io.out_r_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    tcdm_arb_id_fifo #(
        .Width (IdW),
        .Depth (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (handshake),
        .push_id_i (winner),
        .pop_i     (pop),
        .head_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (outstanding_o)
    );

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
module tb_tcdm_rr_arbiter;
    import tcdm_arb_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 2;
    localparam int unsigned CW = $clog2(MO + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [CW-1:0] outstanding_o;
    logic          err_o;

    tcdm_rr_arbiter_if #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    tcdm_rr_arbiter #(
        .N_PORTS         (NP),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .bus_io        (bus),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];      // expected responses, in issue order
    logic [31:0] mem_q[$];   // memory model: data still to be returned
    int          m_ptr;
    int          m_out;
    bit          m_err;

    tcdm_req_t   rq [NP];
    logic [NP-1:0] pend;

    bit          mem_en, rv_rand, gnt_rand, spurious;
    logic [NP-1:0] auto_mask;
    int          auto_pct;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tag(input logic [31:0] a, input logic wen);
        return a ^ (wen ? 32'hA5A5_0000 : 32'h0000_5A5A);
    endfunction

    function automatic tcdm_req_t rand_req();
        tcdm_req_t r;
        r.add  = $urandom;
        r.wen  = 1'($urandom % 2);
        r.be   = 4'($urandom);
        r.data = $urandom;
        return r;
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            bus.in_req_i[p]  = pend[p];
            bus.in_add_i[p]  = rq[p].add;
            bus.in_wen_i[p]  = rq[p].wen;
            bus.in_be_i[p]   = rq[p].be;
            bus.in_data_i[p] = rq[p].data;
        end
    endtask

    // One clock cycle: entered and left at posedge + 1.
    task automatic cycle();
        int   w;
        bit   rv, exp_oreq, hs;
        logic [31:0] rdata;
        for (int p = 0; p < NP; p++) begin
            if (auto_mask[p] && !pend[p] && $urandom_range(99) < auto_pct) begin
                pend[p] = 1'b1;
                rq[p]   = rand_req();
            end
        end
        drive();
        bus.out_gnt_i = gnt_rand ? ($urandom_range(3) != 0) : 1'b1;
        rv    = spurious || (mem_en && mem_q.size() > 0 && (!rv_rand || $urandom_range(1) == 1));
        rdata = spurious ? $urandom : (rv ? mem_q[0] : 32'h0);
        bus.out_r_valid_i = rv;
        bus.out_r_data_i  = rdata;
        #2;
        w = -1;
        for (int i = 0; i < NP; i++) begin
            if (w < 0 && pend[(m_ptr + i) % NP]) w = (m_ptr + i) % NP;
        end
        exp_oreq = (w >= 0) && (m_out < MO);
        hs       = exp_oreq && bus.out_gnt_i;
        chk("out_req", bus.out_req_o, exp_oreq);
        chk("in_gnt", bus.in_gnt_o, hs ? (4'b0001 << w) : 4'b0000);
        chk("out_add", bus.out_add_o, exp_oreq ? rq[w].add : 32'h0);
        chk("out_wen", bus.out_wen_o, exp_oreq ? rq[w].wen : 1'b0);
        chk("out_be", bus.out_be_o, exp_oreq ? rq[w].be : 4'h0);
        chk("out_data", bus.out_data_o, exp_oreq ? rq[w].data : 32'h0);
        chk("outstanding", outstanding_o, m_out);
        chk("err", err_o, m_err);
        chk("rvalid_any", |bus.in_r_valid_o, rv && m_out > 0);
        if (rv) begin
            if (!spurious) void'(mem_q.pop_front());
            if (m_out > 0) m_out--;
            else m_err = 1'b1;
        end
        if (hs) begin
            sb.push_back('{w, tag(rq[w].add, rq[w].wen)});
            mem_q.push_back(tag(rq[w].add, rq[w].wen));
            m_out++;
            m_ptr   = (w + 1) % NP;
            pend[w] = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive();
        bus.out_gnt_i     = 1'b1;
        bus.out_r_valid_i = 1'b1;
        bus.out_r_data_i  = $urandom;
        rst_i = 1'b1;
        #1;
        chk("rst_out_req", bus.out_req_o, 1'b0);
        chk("rst_in_gnt", bus.in_gnt_o, 4'b0000);
        chk("rst_r_valid", bus.in_r_valid_o, 4'b0000);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err", err_o, 1'b0);
        m_ptr = 0;
        m_out = 0;
        m_err = 1'b0;
        sb.delete();
        mem_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bus.out_r_valid_i = 1'b0;
    endtask

    task automatic drain();
        auto_mask = '0;
        mem_en    = 1'b1;
        rv_rand   = 1'b0;
        gnt_rand  = 1'b0;
        for (int i = 0; i < 30 && (m_out > 0 || pend != '0); i++) cycle();
        chk("drain_outstanding", m_out, 0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    // Response monitor: every routed response must match the oldest expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && bus.in_r_valid_o != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got r_valid %b expected none at %0t",
                         bus.in_r_valid_o, $time);
            end else begin
                e = sb.pop_front();
                chk("resp_port", bus.in_r_valid_o, 4'b0001 << e.port);
                chk("resp_data", bus.in_r_data_o, e.data);
            end
        end
    end

    initial begin
        pend = '0;
        for (int p = 0; p < NP; p++) rq[p] = rand_req();
        auto_mask = '0; auto_pct = 0;
        mem_en = 1'b1; rv_rand = 1'b0; gnt_rand = 1'b0; spurious = 1'b0;
        drive();
        bus.out_gnt_i = 1'b0; bus.out_r_valid_i = 1'b0; bus.out_r_data_i = '0;
        @(posedge clk_i);
        #1;
        pend = '1;
        do_reset();
        pend = '0;

        // Lone requester: port 2 reads 0x100 three cycles in a row.
        for (int i = 0; i < 3; i++) begin
            pend[2] = 1'b1;
            rq[2]   = '{add: 32'h100, wen: 1'b1, be: 4'hF, data: 32'h0};
            cycle();
        end
        drain();

        // All ports requesting from reset: 0,1,2,3,0,1,...
        do_reset();
        auto_mask = '1; auto_pct = 100;
        for (int i = 0; i < 8; i++) cycle();
        drain();

        // Full stall, then one response frees a slot for port 2.
        do_reset();
        mem_en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            pend[p] = 1'b1;
            rq[p]   = rand_req();
        end
        for (int i = 0; i < 3; i++) cycle();
        mem_en = 1'b1;
        cycle();
        mem_en = 1'b0;
        cycle();
        drain();

        // Write from port 1, then a read from port 3.
        pend[1] = 1'b1;
        rq[1]   = '{add: $urandom, wen: 1'b0, be: 4'b0011, data: 32'hDEADBEEF};
        cycle();
        pend[3] = 1'b1;
        rq[3]   = rand_req();
        rq[3].wen = 1'b1;
        cycle();
        drain();

        // Response with nothing outstanding.
        spurious = 1'b1;
        cycle();
        spurious = 1'b0;
        for (int i = 0; i < 2; i++) cycle();

        // Random traffic; err_o must stay set throughout.
        auto_mask = '1; auto_pct = 40;
        gnt_rand = 1'b1; rv_rand = 1'b1; mem_en = 1'b1;
        for (int i = 0; i < 300; i++) cycle();
        drain();

        // Reset with two transactions in flight; pointer restarts at 0.
        mem_en = 1'b0;
        pend[1] = 1'b1; rq[1] = rand_req();
        pend[3] = 1'b1; rq[3] = rand_req();
        for (int i = 0; i < 2; i++) cycle();
        chk("pre_reset_outstanding", outstanding_o, MO);
        pend = '1;
        for (int p = 0; p < NP; p++) rq[p] = rand_req();
        do_reset();
        mem_en = 1'b1;
        cycle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
